// File: rtl/live_edge_conditioner.sv
// Synchronises and deglitches the LIVE spill gate, enforces the inter-spill
// holdoff and measures spill length in clock cycles.
module live_edge_conditioner #(
  parameter int unsigned FILT_LEN = 8,
  parameter int unsigned MIN_GAP  = 1024
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        live_in,
  output logic        live_level,
  output logic        live_rising,
  output logic        live_falling,
  output logic [31:0] live_len,
  output logic        len_valid,
  output logic [15:0] glitch_cnt
);

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] LIVE = 2'd1;
  localparam logic [1:0] HOLD = 2'd2;

  localparam logic [7:0]  FMAX = 8'(FILT_LEN - 1);
  localparam logic [15:0] GMAX = 16'(MIN_GAP - 1);

  logic        s1_q, s2_q;
  logic [1:0]  state_q, state_d;
  logic        level_q, level_d;
  logic [7:0]  fcnt_q, fcnt_d;
  logic [15:0] glitch_q, glitch_d;
  logic [31:0] run_q, run_d;
  logic [15:0] gap_q, gap_d;
  logic [31:0] len_q, len_d;
  logic        rise_q, rise_d;
  logic        fall_q, fall_d;
  logic        lv_q, lv_d;

  logic diff;
  logic hold;
  logic accept;

  assign diff   = s2_q != level_q;
  assign hold   = state_q == HOLD;
  assign accept = diff && (fcnt_q == FMAX) && !hold;

  always_comb begin
    state_d  = state_q;
    level_d  = level_q;
    fcnt_d   = fcnt_q;
    glitch_d = glitch_q;
    run_d    = run_q;
    gap_d    = gap_q;
    len_d    = len_q;
    rise_d   = 1'b0;
    fall_d   = 1'b0;
    lv_d     = 1'b0;

    // Filter is frozen during holdoff: no accepts, no glitches.
    if (hold) begin
      fcnt_d = 8'd0;
    end else if (diff) begin
      fcnt_d = accept ? 8'd0 : fcnt_q + 8'd1;
    end else begin
      fcnt_d = 8'd0;
      if (fcnt_q != 8'd0 && glitch_q != 16'hFFFF)
        glitch_d = glitch_q + 16'd1;
    end

    unique case (1'b1)
      (state_q == IDLE): begin
        if (accept) begin
          state_d = LIVE;
          level_d = 1'b1;
          rise_d  = 1'b1;
          run_d   = 32'd1;
        end
      end
      (state_q == LIVE): begin
        if (accept) begin
          state_d = HOLD;
          level_d = 1'b0;
          fall_d  = 1'b1;
          len_d   = run_q;
          lv_d    = 1'b1;
          gap_d   = GMAX;
        end else if (run_q != 32'hFFFF_FFFF) begin
          run_d = run_q + 32'd1;
        end
      end
      (state_q == HOLD): begin
        if (gap_q == 16'd0)
          state_d = IDLE;
        else
          gap_d = gap_q - 16'd1;
      end
      default: begin
        state_d = IDLE;
        level_d = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      s1_q     <= 1'b0;
      s2_q     <= 1'b0;
      state_q  <= IDLE;
      level_q  <= 1'b0;
      fcnt_q   <= 8'd0;
      glitch_q <= 16'd0;
      run_q    <= 32'd0;
      gap_q    <= 16'd0;
      len_q    <= 32'd0;
      rise_q   <= 1'b0;
      fall_q   <= 1'b0;
      lv_q     <= 1'b0;
    end else begin
      s1_q     <= live_in;
      s2_q     <= s1_q;
      state_q  <= state_d;
      level_q  <= level_d;
      fcnt_q   <= fcnt_d;
      glitch_q <= glitch_d;
      run_q    <= run_d;
      gap_q    <= gap_d;
      len_q    <= len_d;
      rise_q   <= rise_d;
      fall_q   <= fall_d;
      lv_q     <= lv_d;
    end
  end

  assign live_level   = level_q;
  assign live_rising  = rise_q;
  assign live_falling = fall_q;
  assign live_len     = len_q;
  assign len_valid    = lv_q;
  assign glitch_cnt   = glitch_q;

endmodule

// File: tb/tb_live_edge_conditioner.sv
// Directed bench for live_edge_conditioner: clean spill, glitches, holdoff,
// async reset, chatter and counter saturation.
module tb_live_edge_conditioner;

  localparam int FL = 4;
  localparam int MG = 16;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        live_in = 1'b0;
  logic        live_level;
  logic        live_rising;
  logic        live_falling;
  logic [31:0] live_len;
  logic        len_valid;
  logic [15:0] glitch_cnt;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int rise_n = 0, fall_n = 0, lv_n = 0, both_n = 0;
  int rise_at = 0, fall_at = 0, lv_at = 0;
  int lvl_hi = 0;
  int cs;
  int h0;

  live_edge_conditioner #(
    .FILT_LEN(FL),
    .MIN_GAP (MG)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .live_in     (live_in),
    .live_level  (live_level),
    .live_rising (live_rising),
    .live_falling(live_falling),
    .live_len    (live_len),
    .len_valid   (len_valid),
    .glitch_cnt  (glitch_cnt)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (live_rising) begin
      rise_n  <= rise_n + 1;
      rise_at <= cyc;
    end
    if (live_falling) begin
      fall_n  <= fall_n + 1;
      fall_at <= cyc;
    end
    if (len_valid) begin
      lv_n  <= lv_n + 1;
      lv_at <= cyc;
    end
    if (live_rising && live_falling)
      both_n <= both_n + 1;
    lvl_hi <= lvl_hi + int'(live_level);
  end

  task automatic chk(input string tag,
                     input logic [31:0] obs,
                     input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic chk_zero(input string tag);
    chk({tag, "_lvl"}, 32'(live_level), 0);
    chk({tag, "_rise"}, 32'(live_rising), 0);
    chk({tag, "_fall"}, 32'(live_falling), 0);
    chk({tag, "_len"}, live_len, 0);
    chk({tag, "_lv"}, 32'(len_valid), 0);
    chk({tag, "_gl"}, 32'(glitch_cnt), 0);
  endtask

  initial begin
    step(2);
    #1;
    chk_zero("rst");
    step(1);
    reset = 1'b1;
    step(5);

    // clean 100-cycle spill
    cs = cyc;
    live_in = 1'b1;
    step(100);
    live_in = 1'b0;
    step(10);
    chk("t1_rise_n", rise_n, 1);
    chk("t1_rise_at", rise_at, cs + 6);
    chk("t1_fall_n", fall_n, 1);
    chk("t1_fall_at", fall_at, cs + 106);
    chk("t1_len", live_len, 100);
    chk("t1_lv_n", lv_n, 1);
    chk("t1_lv_at", lv_at, cs + 106);
    chk("t1_gl", 32'(glitch_cnt), 0);
    chk("t1_lvl", 32'(live_level), 0);
    step(20);

    // 3-cycle glitch
    live_in = 1'b1;
    step(3);
    live_in = 1'b0;
    step(2);
    chk("t2_gl_pre", 32'(glitch_cnt), 0);
    step(1);
    chk("t2_gl_post", 32'(glitch_cnt), 1);
    step(6);
    chk("t2_rise_n", rise_n, 1);
    chk("t2_lvl", 32'(live_level), 0);

    // 4-cycle pulse, then re-assert inside holdoff
    cs = cyc;
    live_in = 1'b1;
    step(4);
    live_in = 1'b0;
    step(8);
    live_in = 1'b1;
    step(17);
    chk("t3_rise_at", rise_at, cs + 6);
    chk("t3_fall_at", fall_at, cs + 10);
    chk("t3_len", live_len, 4);
    chk("t3_hold_rise_n", rise_n, 2);
    chk("t3_hold_gl", 32'(glitch_cnt), 1);
    step(3);
    chk("t3_rise_n", rise_n, 3);
    chk("t3_rise_gap", rise_at, cs + 30);
    chk("t3_lvl", 32'(live_level), 1);

    // async reset 50 cycles into the spill
    step(48);
    reset = 1'b0;
    #1;
    chk_zero("mid");
    step(3);
    reset = 1'b1;
    cs = cyc;
    step(10);
    chk("t4_rise_n", rise_n, 4);
    chk("t4_rise_at", rise_at, cs + 6);
    chk("t4_fall_n", fall_n, 2);
    chk("t4_lv_n", lv_n, 2);
    live_in = 1'b0;
    step(10);
    chk("t4_len", live_len, 10);
    chk("t4_fall_at", fall_at, cs + 16);
    step(20);

    // chatter every cycle for 200 cycles
    h0 = lvl_hi;
    for (int i = 0; i < 200; i++) begin
      live_in = (i % 2 == 0);
      step(1);
    end
    live_in = 1'b0;
    step(8);
    chk("t6_gl", 32'(glitch_cnt), 100);
    chk("t6_rise_n", rise_n, 4);
    chk("t6_fall_n", fall_n, 3);
    chk("t6_lvl", lvl_hi - h0, 0);

    // glitch counter saturation
    force dut.glitch_q = 16'hFFFE;
    step(1);
    release dut.glitch_q;
    step(1);
    chk("t5_gl_pre", 32'(glitch_cnt), 32'h0000_FFFE);
    for (int i = 0; i < 3; i++) begin
      live_in = 1'b1;
      step(1);
      live_in = 1'b0;
      step(3);
    end
    step(3);
    chk("t5_gl_sat", 32'(glitch_cnt), 32'h0000_FFFF);
    step(5);
    chk("t5_gl_hold", 32'(glitch_cnt), 32'h0000_FFFF);

    // spill length saturation
    live_in = 1'b1;
    step(7);
    chk("t5_rise_n", rise_n, 5);
    force dut.run_q = 32'hFFFF_FFF0;
    step(1);
    release dut.run_q;
    step(30);
    live_in = 1'b0;
    step(10);
    chk("t5_lv_n", lv_n, 4);
    chk("t5_len_sat", live_len, 32'hFFFF_FFFF);
    chk("both_pulse", both_n, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
